fb_uart_dump: RTL and testbench

Frame-buffer readback engine: on a start request it reads every 1-bit pixel of the monochrome frame buffer in address order, packs 8 pixels per byte (first pixel in bit 7), and hands each byte to the UART transmitter. It is the return path to the UART-fed frame-buffer writer: the host reads the displayed image back over the same serial link. It sits between a dedicated read port of the frame-buffer RAM and the `UART` transmit inputs (`txDataIN`, `txLoadIN`, `txReadyOUT`).

---
 rtl/fb_uart_dump_pkg.sv | 20 ++
 rtl/fb_uart_dump_if.sv | 28 ++
 rtl/fb_uart_dump_bit_packer.sv | 25 ++
 rtl/fb_uart_dump.sv | 114 +++++++++++
 tb/tb_fb_uart_dump.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_uart_dump_pkg.sv
// Shared definitions for the frame-buffer readback path: FSM encoding,
// packing geometry and default frame size.
package fb_uart_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int unsigned PIXELS_PER_BYTE = 8;
  localparam int unsigned FRAME_W         = 320;
  localparam int unsigned FRAME_H         = 240;
  localparam int unsigned FRAME_PIXELS    = FRAME_W * FRAME_H;

  // Fetch phase counter must reach PIXELS_PER_BYTE (the trailing capture cycle)
  localparam int unsigned FETCH_CNT_W     = 4;

endpackage

// File: rtl/fb_uart_dump_if.sv
// Frame-buffer read port plus UART transmit handshake seen by the dump engine.
interface fb_uart_dump_if #(
  parameter int unsigned ADDR_WIDTH = 17
) ();

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_data;
  logic [7:0]            tx_data;
  logic                  tx_load;
  logic                  tx_ready;

  modport master (
    output rd_addr,
    output tx_data,
    output tx_load,
    input  rd_data,
    input  tx_ready
  );

  modport slave (
    input  rd_addr,
    input  tx_data,
    input  tx_load,
    output rd_data,
    output tx_ready
  );

endinterface

// File: rtl/fb_uart_dump_bit_packer.sv
// MSB-first 8-bit shift register: first captured pixel ends up in bit 7.
module fb_uart_dump_bit_packer
  import fb_uart_dump_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       cap,
  input  logic                       zero_fill,
  input  logic                       bit_in,
  output logic [PIXELS_PER_BYTE-1:0] byte_q
);

  // Zero-fill forces padding bits for pixels past the end of the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q <= '0;
    end else if (clr) begin
      byte_q <= '0;
    end else if (cap) begin
      byte_q <= {byte_q[PIXELS_PER_BYTE-2:0], bit_in & ~zero_fill};
    end
  end

endmodule

// File: rtl/fb_uart_dump.sv
// Frame-buffer readback engine: streams the 1-bit frame buffer, 8 pixels
// per byte, into the UART transmitter on a start request.
module fb_uart_dump
  import fb_uart_dump_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned FB_PIXELS  = FRAME_PIXELS
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  fb_uart_dump_if.master bus
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]       PIX_END    = CNT_W'(FB_PIXELS);
  localparam logic [FETCH_CNT_W-1:0] LAST_ISSUE = FETCH_CNT_W'(PIXELS_PER_BYTE - 1);
  localparam logic [FETCH_CNT_W-1:0] LAST_CAP   = FETCH_CNT_W'(PIXELS_PER_BYTE);

  state_e                     state_q, state_d;
  logic [FETCH_CNT_W-1:0]     fcnt_q, fcnt_d;
  logic [CNT_W-1:0]           pix_q, pix_c;
  logic                       iss_q, cap_vld_q;
  logic                       issue_c, clr_c, cap_c, load_c, done_c;
  logic [PIXELS_PER_BYTE-1:0] pack_q;

  // Next-state and strobe decode
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    clr_c   = 1'b0;
    cap_c   = 1'b0;
    load_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // done is still high in the first IDLE cycle; a start there is ignored
        if (start && !done) begin
          state_d = ST_FETCH;
          fcnt_d  = '0;
          clr_c   = 1'b1;
        end
      end
      ST_FETCH: begin
        cap_c  = (fcnt_q != '0);
        fcnt_d = fcnt_q + FETCH_CNT_W'(1);
        if (fcnt_q == LAST_CAP) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          load_c  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (pix_q >= PIX_END) begin
          state_d = ST_IDLE;
          done_c  = 1'b1;
        end else begin
          state_d = ST_FETCH;
          fcnt_d  = '0;
          clr_c   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address for next cycle: pixel counter restarts at 0 from IDLE
  always_comb begin
    pix_c   = (state_q == ST_IDLE) ? '0 : pix_q;
    issue_c = (state_d == ST_FETCH) && (fcnt_d <= LAST_ISSUE) && (pix_c < PIX_END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fcnt_q      <= '0;
      pix_q       <= '0;
      iss_q       <= 1'b0;
      cap_vld_q   <= 1'b0;
      bus.rd_addr <= '0;
      bus.tx_data <= '0;
      bus.tx_load <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pix_q     <= pix_c + CNT_W'(issue_c);
      iss_q     <= issue_c;
      cap_vld_q <= iss_q;
      if (issue_c) bus.rd_addr <= pix_c[ADDR_WIDTH-1:0];
      if (load_c)  bus.tx_data <= pack_q;
      bus.tx_load <= load_c;
      busy        <= (state_d != ST_IDLE);
      done        <= done_c;
    end
  end

  // Capture slots with no issued address shift in padding zeros
  fb_uart_dump_bit_packer u_packer (
    .clk       (clk),
    .rst       (reset),
    .clr       (clr_c),
    .cap       (cap_c),
    .zero_fill (~cap_vld_q),
    .bit_in    (bus.rd_data),
    .byte_q    (pack_q)
  );

endmodule

// File: tb/tb_fb_uart_dump.sv
// Randomised scoreboard bench for fb_uart_dump: 20-pixel frame (3 bytes,
// last one half padded) on a 5-bit address bus.
module tb_fb_uart_dump;

  localparam int unsigned AW  = 5;
  localparam int unsigned FBP = 20;
  localparam int unsigned NB  = (FBP + 7) / 8;
  localparam int unsigned MEM = 1 << AW;

  logic clk = 1'b0;
  logic reset, start, busy, done;

  fb_uart_dump_if #(.ADDR_WIDTH(AW)) bus ();

  fb_uart_dump #(.ADDR_WIDTH(AW), .FB_PIXELS(FBP)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  logic       ram [0:MEM-1];
  logic [7:0] exp_q [$];
  int         n_checks = 0, n_fail = 0;
  int         n_load = 0, n_done = 0, cyc = 0, prev_load_cyc = -1;
  bit         tie_high = 1'b0, stall = 1'b1, stall_chk = 1'b0;
  bit         stall_bad = 1'b0, addr_bad = 1'b0, last_load = 1'b0;
  logic [7:0] stall_data = '0;
  int         hold_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous-read RAM: data for the address seen at an edge appears after it
  initial begin
    bus.rd_data = 1'b0;
    forever begin
      @(posedge clk);
      bus.rd_data <= ram[bus.rd_addr];
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model: ready drops after each load for a random time
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall) bus.tx_ready = 1'b0;
      else if (tie_high) bus.tx_ready = 1'b1;
      else if (bus.tx_load) begin
        bus.tx_ready = 1'b0;
        hold_cnt = int'($urandom_range(0, 20));
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        bus.tx_ready = 1'b0;
      end else bus.tx_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every load
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_load_cyc = -1;
        last_load = 1'b0;
      end else begin
        if (bus.tx_load) begin
          n_load++;
          check("load_width", 32'(last_load), 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_load: got byte %0h, no byte expected", bus.tx_data);
          end else begin
            exp_b = exp_q.pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(exp_b));
          end
          if (tie_high && prev_load_cyc >= 0)
            check("load_gap", 32'(cyc - prev_load_cyc), 32'd11);
          prev_load_cyc = cyc;
        end
        last_load = bus.tx_load;
        if (done) n_done++;
        if (busy && (32'(bus.rd_addr) >= FBP)) addr_bad = 1'b1;
        if (stall_chk && (bus.tx_load || bus.tx_data !== stall_data)) stall_bad = 1'b1;
      end
    end
  end

  // mode 0: random pixels, 1: all ones, 2: fixed pattern; unused tail is 1s
  task automatic fill_ram(input int mode);
    logic [15:0] pat;
    logic [3:0]  tail;
    pat  = 16'hAAF0;
    tail = 4'b1011;
    for (int i = 0; i < int'(MEM); i++) begin
      if (i >= int'(FBP))  ram[i] = 1'b1;
      else if (mode == 1)  ram[i] = 1'b1;
      else if (mode == 2)  ram[i] = (i < 16) ? pat[15 - i] : tail[19 - i];
      else                 ram[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Reference: byte b bit (7-k) is pixel 8b+k, zero past the frame end
  task automatic launch();
    for (int b = 0; b < int'(NB); b++) begin
      logic [7:0] v;
      v = '0;
      for (int k = 0; k < 8; k++)
        v[7 - k] = (b * 8 + k < int'(FBP)) ? ram[b * 8 + k] : 1'b0;
      exp_q.push_back(v);
    end
    n_done = 0;
    addr_bad = 1'b0;
    prev_load_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("first_addr", 32'(bus.rd_addr), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (n_done == 0 && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("done_seen", 32'(n_done != 0), 32'd1);
  endtask

  task automatic finish_dump(input int base);
    repeat (3) @(negedge clk);
    #1;
    check("done_count", 32'(n_done), 32'd1);
    check("load_count", 32'(n_load - base), 32'(NB));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("addr_range", 32'(addr_bad), 32'd0);
  endtask

  task automatic run_dump(input int mode, input bit tie);
    int base;
    fill_ram(mode);
    tie_high = tie;
    base = n_load;
    launch();
    wait_done(2000);
    finish_dump(base);
  endtask

  initial begin
    int base, t;
    bit bad;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < int'(MEM); i++) ram[i] = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("rst_outputs", 32'({bus.rd_addr, bus.tx_data, bus.tx_load, busy, done}), 32'd0);
    reset = 1'b0;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if ({bus.rd_addr, bus.tx_data, bus.tx_load, busy, done} != '0) bad = 1'b1;
    end
    check("idle_100", 32'(bad), 32'd0);
    stall = 1'b0;

    // Fixed pattern and all-ones frames with ready tied high
    run_dump(2, 1'b1);
    run_dump(1, 1'b1);

    // Random frames against a randomly slow transmitter
    repeat (4) run_dump(0, 1'b0);

    // Transmitter not ready for 500 cycles in SEND
    fill_ram(0);
    tie_high = 1'b0;
    stall = 1'b1;
    base = n_load;
    launch();
    repeat (20) @(negedge clk);
    stall_data = bus.tx_data;
    stall_bad = 1'b0;
    stall_chk = 1'b1;
    repeat (500) @(negedge clk);
    stall_chk = 1'b0;
    #1;
    check("stall_stable", 32'(stall_bad), 32'd0);
    check("stall_no_load", 32'(n_load - base), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    wait_done(2000);
    finish_dump(base);

    // Extra starts mid-dump and in the done cycle are ignored
    fill_ram(0);
    tie_high = 1'b0;
    base = n_load;
    launch();
    repeat (15) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("done_for_restart", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("start_at_done_ignored", 32'(busy), 32'd0);
    finish_dump(base);

    // Reset during the third byte's fetch, then a clean restart
    fill_ram(0);
    tie_high = 1'b1;
    launch();
    t = 0;
    while (n_load < base + int'(NB) + 2 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("two_loads_before_reset", 32'(n_load - base - int'(NB)), 32'd2);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_tx", 32'({bus.tx_data, bus.tx_load}), 32'd0);
    check("async_rst_addr", 32'(bus.rd_addr), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run_dump(0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
